// File: rtl/czmuldiv_seq.sv
// Control sequencer for 8x8 shift-add multiply and 16/8 restoring divide on the
// czabcd A/B/C/D datapath; owns the datapath control inputs while BUSY is high.
module czmuldiv_seq #(
  parameter int STEPS = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       OP,
  input  logic       xCY_P,
  input  logic       xAMSB_P,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVF,
  output logic       xASEL_P,
  output logic       xCMPSUB_P,
  output logic [1:0] xADDLSEL_P,
  output logic [1:0] xADDRSEL_P,
  output logic [3:0] xBCSEL_P,
  output logic       xMUL_P,
  output logic       xNOT_P,
  output logic       xONE_P,
  output logic       xCYCF_P,
  output logic       xCF_P,
  output logic       xCFBIT_P,
  output logic [1:0] xLALUOP_P,
  output logic       xINPUT_P,
  output logic       xDSEL_P
);

  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MSETUP = 3'd1,
    MSTEP  = 3'd2,
    DCHECK = 3'd3,
    DSTEP  = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf_nxt;
  logic             q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      OVF   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      OVF   <= ovf_nxt;
    end
  end

  // Quotient bit: subtraction succeeded, or the shifted remainder already exceeded 8 bits.
  assign q = xCY_P | xAMSB_P;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ovf_nxt    = OVF;
    BUSY       = (state != IDLE);
    DONE       = 1'b0;
    xASEL_P    = 1'b0;
    xCMPSUB_P  = 1'b0;
    xADDLSEL_P = 2'b00;
    xADDRSEL_P = 2'b00;
    xBCSEL_P   = 4'b0000;
    xMUL_P     = 1'b0;
    xNOT_P     = 1'b0;
    xONE_P     = 1'b0;
    xCYCF_P    = 1'b0;
    xCF_P      = 1'b0;
    xCFBIT_P   = 1'b0;
    xLALUOP_P  = 2'b00;
    xINPUT_P   = 1'b0;
    xDSEL_P    = 1'b0;

    case (state)
      IDLE: begin
        if (START) begin
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          state_nxt = OP ? DCHECK : MSETUP;
        end
      end
      MSETUP: begin
        xBCSEL_P  = 4'b0100;
        state_nxt = MSTEP;
      end
      MSTEP: begin
        xMUL_P     = 1'b1;
        xADDLSEL_P = 2'b01;
        xADDRSEL_P = 2'b01;
        xBCSEL_P   = 4'b1111;
        if (cnt == LAST) state_nxt = FIN;
        else             cnt_nxt   = cnt + 1'b1;
      end
      DCHECK: begin
        // A >= D (incl. D == 0) means the quotient cannot fit in 8 bits.
        xADDLSEL_P = 2'b01;
        xADDRSEL_P = 2'b11;
        xNOT_P     = 1'b1;
        xONE_P     = 1'b1;
        if (xCY_P) begin
          ovf_nxt   = 1'b1;
          state_nxt = FIN;
        end else begin
          state_nxt = DSTEP;
        end
      end
      DSTEP: begin
        xADDLSEL_P = 2'b10;
        xADDRSEL_P = 2'b11;
        xNOT_P     = 1'b1;
        xONE_P     = 1'b1;
        xASEL_P    = 1'b1;
        xBCSEL_P   = 4'b1010;
        xCYCF_P    = q;
        xCMPSUB_P  = ~q;
        if (cnt == LAST) state_nxt = FIN;
        else             cnt_nxt   = cnt + 1'b1;
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_czmuldiv_seq.sv
// Directed bench for czmuldiv_seq driving a behavioural model of the czabcd
// A/B/C/D datapath from the sequencer's control outputs.
module tb_czmuldiv_seq;

  logic       CLK = 1'b0;
  logic       RST, START, OP;
  logic       xCY_P, xAMSB_P;
  logic       BUSY, DONE, OVF;
  logic       xASEL_P, xCMPSUB_P, xMUL_P, xNOT_P, xONE_P, xCYCF_P;
  logic       xCF_P, xCFBIT_P, xINPUT_P, xDSEL_P;
  logic [1:0] xADDLSEL_P, xADDRSEL_P, xLALUOP_P;
  logic [3:0] xBCSEL_P;

  always #5 CLK = ~CLK;

  czmuldiv_seq #(.STEPS(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP),
    .xCY_P(xCY_P), .xAMSB_P(xAMSB_P),
    .BUSY(BUSY), .DONE(DONE), .OVF(OVF),
    .xASEL_P(xASEL_P), .xCMPSUB_P(xCMPSUB_P),
    .xADDLSEL_P(xADDLSEL_P), .xADDRSEL_P(xADDRSEL_P), .xBCSEL_P(xBCSEL_P),
    .xMUL_P(xMUL_P), .xNOT_P(xNOT_P), .xONE_P(xONE_P), .xCYCF_P(xCYCF_P),
    .xCF_P(xCF_P), .xCFBIT_P(xCFBIT_P), .xLALUOP_P(xLALUOP_P),
    .xINPUT_P(xINPUT_P), .xDSEL_P(xDSEL_P)
  );

  logic [19:0] ctl;
  assign ctl = {xASEL_P, xCMPSUB_P, xADDLSEL_P, xADDRSEL_P, xBCSEL_P, xMUL_P,
                xNOT_P, xONE_P, xCYCF_P, xCF_P, xCFBIT_P, xLALUOP_P, xINPUT_P, xDSEL_P};

  // Datapath model
  logic [7:0] ra, rb, rc, rd;
  logic       ld_en;
  logic [7:0] ld_a, ld_b, ld_c, ld_d;
  logic [7:0] left, right, ans, diva;
  logic       cy;

  always_comb begin
    diva = {ra[6:0], rb[7]};
    case (xADDLSEL_P)
      2'b01:   left = ra;
      2'b10:   left = diva;
      default: left = 8'h00;
    endcase
    if (xMUL_P && !rc[0]) left = 8'h00;
    case (xADDRSEL_P)
      2'b01:   right = rb;
      2'b11:   right = rd;
      default: right = 8'h00;
    endcase
    if (xNOT_P) right = ~right;
    {cy, ans} = {1'b0, left} + {1'b0, right} + {8'h00, xONE_P};
  end

  assign xCY_P   = cy;
  assign xAMSB_P = ra[7];

  always_ff @(posedge CLK) begin
    if (ld_en) begin
      ra <= ld_a; rb <= ld_b; rc <= ld_c; rd <= ld_d;
    end else begin
      if (xASEL_P) ra <= xCMPSUB_P ? diva : ans;
      case (xBCSEL_P[3:2])
        2'b01:   rb <= ans;
        2'b11:   rb <= {cy, ans[7:1]};
        2'b10:   rb <= {rb[6:0], 1'b0};
        default: rb <= rb;
      endcase
      case (xBCSEL_P[1:0])
        2'b11:   rc <= {ans[0], rc[7:1]};
        2'b10:   rc <= {rc[6:0], xCYCF_P};
        default: rc <= rc;
      endcase
    end
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    ld_a = a; ld_b = b; ld_c = c; ld_d = d; ld_en = 1'b1;
    @(negedge CLK);
    ld_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where DONE is seen (or bound hit).
  task automatic run(input logic op_i, input int poke, output int cyc);
    cyc = 0; OP = op_i; START = 1'b1;
    do begin
      @(negedge CLK);
      cyc++;
      START = (cyc == poke);
    end while (!DONE && cyc < 40);
    START = 1'b0;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; OP = 1'b0; ld_en = 1'b0;
    ld_a = '0; ld_b = '0; ld_c = '0; ld_d = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ctl", ctl, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_ovf", OVF, 0);
    RST = 1'b0;
    @(negedge CLK);

    load(8'd13, 8'h00, 8'd11, 8'h00);
    run(1'b0, 0, n);
    chk("mul13_lat", n, 10);
    chk("mul13_bc", {rb, rc}, 16'h008F);
    chk("mul13_a", ra, 8'd13);
    chk("mul13_ovf", OVF, 0);
    chk("mul13_busy_fin", BUSY, 1);
    @(negedge CLK);
    chk("mul13_done_pulse", DONE, 0);
    chk("mul13_idle_busy", BUSY, 0);

    load(8'hFF, 8'h00, 8'hFF, 8'h00);
    run(1'b0, 0, n);
    chk("mulff_lat", n, 10);
    chk("mulff_bc", {rb, rc}, 16'hFE01);

    load(8'h01, 8'hF4, 8'h00, 8'd7);
    run(1'b1, 0, n);
    chk("div500_lat", n, 10);
    chk("div500_q", rc, 8'h47);
    chk("div500_r", ra, 8'd3);
    chk("div500_ovf", OVF, 0);

    load(8'h7F, 8'hFF, 8'h00, 8'h80);
    run(1'b1, 0, n);
    chk("div7fff_q", rc, 8'hFF);
    chk("div7fff_r", ra, 8'h7F);

    load(8'h00, 8'h05, 8'h5A, 8'h00);
    run(1'b1, 0, n);
    chk("divz_lat", n, 2);
    chk("divz_ovf", OVF, 1);
    chk("divz_abc", {ra, rb, rc}, 24'h00055A);
    @(negedge CLK);
    chk("divz_ovf_held", OVF, 1);

    load(8'h10, 8'h00, 8'h33, 8'h10);
    run(1'b1, 0, n);
    chk("divov_lat", n, 2);
    chk("divov_ovf", OVF, 1);
    chk("divov_ac", {ra, rc}, 16'h1033);

    load(8'h03, 8'h00, 8'h05, 8'h00);
    run(1'b0, 0, n);
    chk("ovf_clear", OVF, 0);
    chk("mul3x5_bc", {rb, rc}, 16'h000F);

    load(8'h25, 8'h00, 8'h06, 8'h00);
    run(1'b0, 4, n);
    chk("midstart_lat", n, 10);
    chk("midstart_bc", {rb, rc}, 16'h00DE);

    load(8'h77, 8'h00, 8'h55, 8'h00);
    OP = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    chk("abort_busy_pre", BUSY, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_busy", BUSY, 0);
    chk("abort_ctl", ctl, 0);
    chk("abort_done", DONE, 0);
    load(8'h0C, 8'h00, 8'h0C, 8'h00);
    run(1'b0, 0, n);
    chk("abort_fresh_lat", n, 10);
    chk("abort_fresh_bc", {rb, rc}, 16'h0090);

    load(8'hA5, 8'h00, 8'h03, 8'h00);
    run(1'b0, 0, n);
    chk("b2b1_bc", {rb, rc}, 16'h01EF);
    load(8'h40, 8'h00, 8'h40, 8'h00);
    run(1'b0, 0, n);
    chk("b2b2_lat", n, 10);
    chk("b2b2_bc", {rb, rc}, 16'h1000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/czmuldiv_seq.md
Name: czmuldiv_seq

Overview:
- Sequencer that runs multi-cycle 8x8 unsigned multiply and 16/8 unsigned restoring divide on the czabcd A/B/C/D datapath.
- Main CTL loads the operands into A/B/C/D, pulses START, waits for DONE, then reads the results.
- While BUSY, this block owns the czabcd control inputs; CTL muxes its own controls back in when BUSY=0.

Parameters:
- STEPS, 8, iterations per operation. Legal range 1..8; 8 gives a full-width result.

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
START  in  1  start request; sampled only in IDLE
OP  in  1  0=multiply, 1=divide; sampled with START
xCY_P  in  1  adder carry from czabcd
xAMSB_P  in  1  A[7] from czabcd
BUSY  out  1  operation in progress
DONE  out  1  one-cycle completion pulse
OVF  out  1  divide overflow / divide-by-zero; held until next accepted START
xASEL_P  out  1  czabcd A load enable
xCMPSUB_P  out  1  A source select (1=diva, restore)
xADDLSEL_P  out  2  adder left select
xADDRSEL_P  out  2  adder right select
xBCSEL_P  out  4  B/C update select
xMUL_P  out  1  gate adder left input by C[0]
xNOT_P  out  1  invert adder right input
xONE_P  out  1  carry-in = 1
xCYCF_P  out  1  C left-shift input bit
xCF_P, xCFBIT_P, xLALUOP_P[1:0], xINPUT_P, xDSEL_P  out  1/1/2/1/1  tied 0 (adder path only; D untouched)

Behaviour:
- Reset: state IDLE, step counter 0, BUSY=DONE=OVF=0, all x*_P outputs 0. Reset mid-operation aborts immediately. Datapath registers keep whatever partial values they hold.
- Idle encoding: all controls 0. xBCSEL_P=0000 leaves B and C unchanged, and A/D are not loaded.
- Operand convention, multiply: A=multiplicand, C=multiplier. Result {B,C} = 16-bit product; A unchanged.
- Operand convention, divide: {A,B}=dividend, D=divisor. Result C=quotient, A=remainder; B is garbage.
- States: IDLE, MSETUP, MSTEP, DCHECK, DSTEP, FIN.
- IDLE: START=1 -> MSETUP if OP=0, DCHECK if OP=1. Counter cleared, OVF cleared. START while not IDLE is ignored, including in FIN.
- MSETUP (1 cycle): clears B.
  - ADDLSEL=00, ADDRSEL=00, BCSEL=0100 (B<=ans=0).
  - Next state: MSTEP.
- MSTEP (STEPS cycles): {CY,ans}=(C[0]?A:0)+B, then B<={CY,ans[7:1]} and C<={ans[0],C[7:1]}.
  - MUL=1, ADDLSEL=01, ADDRSEL=01, BCSEL=1111.
  - Counter increments each cycle; after the STEPS-th cycle -> FIN.
- DCHECK (1 cycle): computes A+~D+1 with no register update.
  - ADDLSEL=01, ADDRSEL=11, NOT=1, ONE=1, ASEL=0, BCSEL=0000.
  - xCY_P=1 (A>=D, which includes D=0): OVF<=1 -> FIN.
  - Otherwise -> DSTEP.
- DSTEP (STEPS cycles): trial subtract of the shifted remainder.
  - ADDLSEL=10 (diva={A[6:0],B[7]}), ADDRSEL=11, NOT=1, ONE=1, ASEL=1, BCSEL=1010 (B left shift, C left shift).
  - Let q = xCY_P | xAMSB_P.
  - Outputs: xCYCF_P=q, xCMPSUB_P=~q. These two are combinational (Mealy) from the inputs in DSTEP only, and 0 in all other states.
  - After the STEPS-th cycle -> FIN.
- FIN (1 cycle): DONE=1, BUSY=1, controls idle -> IDLE.
- BUSY=1 in every state except IDLE.
- Latency: START sampled at edge k. DONE is high in cycle k+2+STEPS (k+10 for STEPS=8), or in cycle k+2 on divide overflow.
- Counter width: clog2(STEPS)+1 bits; compares with STEPS-1, no wrap.
- All outputs except xCYCF_P and xCMPSUB_P are registered-state decodes (Moore).

Test Plan:
- Multiply: A=13, C=11, OP=0 pulse START -> DONE exactly 10 cycles later; {B,C}=0x008F; A=13; OVF=0.
- Multiply: A=0xFF, C=0xFF -> {B,C}=0xFE01 (top carry captured via xCY_P into B[7]).
- Divide: {A,B}=0x01F4 (500), D=7 -> DONE 10 cycles after START; C=0x47 (71), A=3, OVF=0.
- Divide by zero and overflow:
  - D=0, {A,B}=0x0005 -> DONE 2 cycles after START, OVF=1, A/B/C unchanged.
  - A=0x10, D=0x10 -> same response.
  - OVF clears on the next START.
- START pulsed again mid-operation -> ignored, result unchanged. RST asserted during MSTEP -> next cycle BUSY=0, all controls 0; a fresh START then completes correctly.
- Back-to-back: START in the cycle after DONE (IDLE) -> accepted; two consecutive multiplies give correct products.
